// File: rtl/cnt_serializer_if.sv
`timescale 1ns/1ps
// cnt_serializer_if: readout-stage handshake plus serial link outputs of the
// count serializer. slave is the serializer's view, master the driver's view.
interface cnt_serializer_if;
   logic       start;
   logic [9:0] word_in;
   logic       rdout_done;
   logic       increment;
   logic       clr_rdout;
   logic       ser_data;
   logic       ser_clk;
   logic       ser_frame;
   logic       busy;
   logic       frame_done;
   logic       err_trailer;

   modport slave (
      input  start, word_in, rdout_done,
      output increment, clr_rdout, ser_data, ser_clk, ser_frame,
             busy, frame_done, err_trailer
   );

   modport master (
      output start, word_in, rdout_done,
      input  increment, clr_rdout, ser_data, ser_clk, ser_frame,
             busy, frame_done, err_trailer
   );
endinterface

// File: rtl/cnt_serializer.sv
`timescale 1ns/1ps
// cnt_serializer: per start pulse, sends header + DATA_WORDS readout words +
// trailer as a gapless MSB-first 10-bit serial stream with bit clock and envelope.
module cnt_serializer #(
   parameter int unsigned BIT_DIV    = 5,
   parameter int unsigned DATA_WORDS = 52,
   parameter int unsigned WORD_LAT   = 3,
   parameter int unsigned INC_HI     = 2
) (
   input logic             clk50,
   input logic             rst,
   cnt_serializer_if.slave bus
);
   localparam int unsigned WORD_CYC = 10 * BIT_DIV;
   localparam int unsigned WC_W     = $clog2(WORD_CYC);
   localparam int unsigned DV_W     = $clog2(BIT_DIV);

   localparam logic [WC_W-1:0] WC_LAST = WC_W'(WORD_CYC - 1);
   localparam logic [WC_W-1:0] WC_CAP  = WC_W'(WORD_LAT - 1);
   localparam logic [WC_W-1:0] WC_INC  = WC_W'(INC_HI);
   localparam logic [DV_W-1:0] DV_LAST = DV_W'(BIT_DIV - 1);
   localparam logic [DV_W-1:0] DV_HALF = DV_W'(BIT_DIV / 2);
   localparam logic [5:0]      IDX_TRL = 6'(DATA_WORDS);
   localparam logic [5:0]      IDX_END = 6'(DATA_WORDS + 1);

   if (BIT_DIV < 2 || WORD_LAT < 1 || INC_HI < 1 ||
       INC_HI + WORD_LAT >= WORD_CYC || DATA_WORDS > 62) begin : g_param_check
      $error("cnt_serializer: illegal BIT_DIV/WORD_LAT/INC_HI/DATA_WORDS combination");
   end

   typedef enum logic [1:0] {IDLE, CLR, SHIFT, DONE} state_t;

   state_t          state, state_nxt;
   logic [DV_W-1:0] div_cnt, div_nxt;
   logic [WC_W-1:0] wcyc, wcyc_nxt;
   logic [5:0]      word_idx, word_nxt;
   logic [9:0]      shift_reg, shift_nxt;
   logic [9:0]      hold_reg, hold_nxt;
   logic            err_q, err_nxt;
   logic            inc_q, inc_nxt;

   always_ff @(posedge clk50) begin
      if (rst) begin
         state     <= IDLE;
         div_cnt   <= '0;
         wcyc      <= '0;
         word_idx  <= '0;
         shift_reg <= '0;
         hold_reg  <= '0;
         err_q     <= 1'b0;
         inc_q     <= 1'b0;
      end else begin
         state     <= state_nxt;
         div_cnt   <= div_nxt;
         wcyc      <= wcyc_nxt;
         word_idx  <= word_nxt;
         shift_reg <= shift_nxt;
         hold_reg  <= hold_nxt;
         err_q     <= err_nxt;
         inc_q     <= inc_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      div_nxt   = div_cnt;
      wcyc_nxt  = wcyc;
      word_nxt  = word_idx;
      shift_nxt = shift_reg;
      hold_nxt  = hold_reg;
      err_nxt   = err_q;

      case (state)
         IDLE: begin
            if (bus.start) begin
               state_nxt = CLR;
               err_nxt   = 1'b0;
            end
         end
         CLR: begin
            shift_nxt = bus.word_in;
            word_nxt  = '0;
            div_nxt   = '0;
            wcyc_nxt  = '0;
            if (bus.rdout_done) err_nxt = 1'b1;
            state_nxt = SHIFT;
         end
         SHIFT: begin
            // Next data word lands in hold_reg WORD_LAT edges into the word.
            if (word_idx < IDX_TRL && wcyc == WC_CAP) begin
               hold_nxt = bus.word_in;
               if (bus.rdout_done) err_nxt = 1'b1;
            end
            if (div_cnt == DV_LAST) begin
               div_nxt   = '0;
               shift_nxt = {shift_reg[8:0], 1'b0};
            end else begin
               div_nxt = div_cnt + DV_W'(1);
            end
            if (wcyc == WC_LAST) begin
               wcyc_nxt = '0;
               if (word_idx < IDX_TRL) begin
                  shift_nxt = hold_reg;
               end else if (word_idx == IDX_TRL) begin
                  shift_nxt = bus.word_in;
                  if (!bus.rdout_done) err_nxt = 1'b1;
               end
               if (word_idx == IDX_END) state_nxt = DONE;
               else                     word_nxt  = word_idx + 6'd1;
            end else begin
               wcyc_nxt = wcyc + WC_W'(1);
            end
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase

      // Registered request strobe: high for the first INC_HI cycles of words 0..DATA_WORDS-1.
      inc_nxt = (state_nxt == SHIFT) && (wcyc_nxt < WC_INC) && (word_nxt < IDX_TRL);
   end

   assign bus.increment   = inc_q;
   assign bus.clr_rdout   = (state == CLR);
   assign bus.ser_frame   = (state == SHIFT);
   assign bus.ser_clk     = (state == SHIFT) && (div_cnt >= DV_HALF);
   assign bus.ser_data    = (state == SHIFT) && shift_reg[9];
   assign bus.busy        = (state != IDLE);
   assign bus.frame_done  = (state == DONE);
   assign bus.err_trailer = err_q;
endmodule

// File: tb/tb_cnt_serializer.sv
`timescale 1ns/1ps
// tb_cnt_serializer: two serializers (BIT_DIV 5 and 2) fed by an upstream
// readout model; a link receiver rebuilds each frame for comparison.
module tb_cnt_serializer;
   localparam int NW = 52;
   localparam int O_INC = 7, O_CLR = 6, O_DAT = 5, O_SCK = 4;
   localparam int O_FRM = 3, O_BSY = 2, O_DON = 1, O_ERR = 0;

   logic             clk50 = 1'b0;
   logic             rst = 1'b1;
   logic             start_r [2] = '{1'b0, 1'b0};
   logic [9:0]       hdr_v [2];
   logic [9:0]       data_v [2][NW];
   logic [9:0]       trl_v [2];
   logic             trl_ok [2];
   logic [7:0]       outs_w [2];
   int               frm_a [2], hi_a [2], inc_a [2], done_a [2], clr_a [2], nb_a [2];
   logic [63:0][9:0] rxw_a [2];
   int               checks = 0;
   int               errors = 0;

   always #10 clk50 = ~clk50;

   cnt_serializer_if bus [2] ();

   for (genvar g = 0; g < 2; g++) begin : g_inst
      logic [9:0]       word_r = '0;
      logic             done_r = 1'b0;
      logic             inc_d = 1'b0;
      int               ptr = 0;
      int               tw = 0;
      logic             frm_d = 1'b0, sclk_d = 1'b0, incm_d = 1'b0;
      logic [9:0]       acc = '0;
      logic [63:0][9:0] rxw = '0;
      int               nb = 0, frm_n = 0, hi_n = 0, inc_n = 0, done_n = 0, clr_n = 0;

      assign bus[g].start      = start_r[g];
      assign bus[g].word_in    = word_r;
      assign bus[g].rdout_done = done_r;
      assign outs_w[g] = {bus[g].increment, bus[g].clr_rdout, bus[g].ser_data, bus[g].ser_clk,
                          bus[g].ser_frame, bus[g].busy, bus[g].frame_done, bus[g].err_trailer};
      assign frm_a[g]  = frm_n;
      assign hi_a[g]   = hi_n;
      assign inc_a[g]  = inc_n;
      assign done_a[g] = done_n;
      assign clr_a[g]  = clr_n;
      assign nb_a[g]   = nb;
      assign rxw_a[g]  = rxw;

      cnt_serializer #(.BIT_DIV(g == 0 ? 5 : 2)) u_dut (
         .clk50 (clk50),
         .rst   (rst),
         .bus   (bus[g])
      );

      // Upstream readout stage: header idles on word_in, one word per increment
      // rising edge, trailer (with rdout_done per trl_ok) shortly after word 52.
      always @(posedge clk50) begin
         inc_d <= bus[g].increment;
         if (bus[g].busy !== 1'b1) begin
            ptr    <= 0;
            tw     <= 0;
            word_r <= hdr_v[g];
            done_r <= 1'b0;
         end else if (bus[g].increment && !inc_d) begin
            if (ptr < NW) begin
               word_r <= data_v[g][ptr];
               ptr    <= ptr + 1;
               if (ptr == NW - 1) tw <= 8;
            end
         end else if (tw != 0) begin
            tw <= tw - 1;
            if (tw == 1) begin
               word_r <= trl_v[g];
               done_r <= trl_ok[g];
            end
         end
      end

      // Link receiver: sample ser_data on ser_clk rising, words aligned to ser_frame.
      always @(negedge clk50) begin
         frm_d  <= bus[g].ser_frame;
         sclk_d <= bus[g].ser_clk;
         incm_d <= bus[g].increment;
         if (bus[g].ser_frame && !frm_d) begin
            nb <= 0;
         end else if (bus[g].ser_clk && !sclk_d) begin
            acc <= {acc[8:0], bus[g].ser_data};
            if (nb % 10 == 9 && nb / 10 < 64) rxw[nb / 10] <= {acc[8:0], bus[g].ser_data};
            nb <= nb + 1;
         end
         if (bus[g].ser_frame) frm_n <= frm_n + 1;
         if (bus[g].ser_frame && bus[g].ser_clk) hi_n <= hi_n + 1;
         if (bus[g].increment && !incm_d) inc_n <= inc_n + 1;
         if (bus[g].frame_done) done_n <= done_n + 1;
         if (bus[g].clr_rdout) clr_n <= clr_n + 1;
      end
   end

   function automatic int bd(input int g);
      return (g == 0) ? 5 : 2;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic prep(input int g, input bit fixed, input bit tok);
      hdr_v[g] = fixed ? 10'h234 : 10'($urandom);
      for (int i = 0; i < NW; i++) data_v[g][i] = fixed ? 10'(32'h100 + i) : 10'($urandom);
      trl_v[g]  = fixed ? 10'h2BF : 10'($urandom);
      trl_ok[g] = tok;
      repeat (3) @(negedge clk50);
   endtask

   task automatic pulse_start(input int g);
      start_r[g] = 1'b1;
      @(negedge clk50);
      start_r[g] = 1'b0;
   endtask

   task automatic run_frame(input int g, input bit fixed, input bit tok, input bit poke);
      int s_frm, s_hi, s_inc, s_done, s_clr, bad, d;
      bit seen;
      logic [9:0] expw;
      d = bd(g);
      prep(g, fixed, tok);
      s_frm = frm_a[g]; s_hi = hi_a[g]; s_inc = inc_a[g]; s_done = done_a[g]; s_clr = clr_a[g];
      pulse_start(g);
      check("clr_pulse", 32'(outs_w[g][O_CLR]), 1);
      check("busy_accept", 32'(outs_w[g][O_BSY]), 1);
      check("err_cleared", 32'(outs_w[g][O_ERR]), 0);
      check("frame_early", 32'(outs_w[g][O_FRM]), 0);
      @(negedge clk50);
      check("frame_rise", 32'({outs_w[g][O_CLR], outs_w[g][O_FRM]}), 1);
      check("inc_first", 32'(outs_w[g][O_INC]), 1);
      check("msb_first", 32'({outs_w[g][O_DAT], outs_w[g][O_SCK]}), 32'({hdr_v[g][9], 1'b0}));
      @(negedge clk50);
      check("inc_second", 32'(outs_w[g][O_INC]), 1);
      @(negedge clk50);
      check("inc_drop", 32'(outs_w[g][O_INC]), 0);
      if (poke) begin
         repeat (497) @(negedge clk50);
         pulse_start(g);
      end
      seen = 1'b0;
      for (int c = 0; c < 20000 && !seen; c++) begin
         @(negedge clk50);
         if (outs_w[g][O_DON] === 1'b1) seen = 1'b1;
      end
      check("done_seen", 32'(seen), 1);
      repeat (4) @(negedge clk50);
      check("frame_len", frm_a[g] - s_frm, 540 * d);
      check("sclk_high", hi_a[g] - s_hi, 540 * (d - d / 2));
      check("inc_pulses", inc_a[g] - s_inc, NW);
      check("done_pulses", done_a[g] - s_done, 1);
      check("clr_cycles", clr_a[g] - s_clr, 1);
      check("rx_bits", nb_a[g], 540);
      bad = 0;
      for (int w = 0; w < NW + 2; w++) begin
         if (w == 0)           expw = hdr_v[g];
         else if (w == NW + 1) expw = trl_v[g];
         else                  expw = data_v[g][w - 1];
         if (rxw_a[g][w] !== expw) bad++;
      end
      check("rx_header", 32'(rxw_a[g][0]), 32'(hdr_v[g]));
      check("rx_trailer", 32'(rxw_a[g][NW + 1]), 32'(trl_v[g]));
      check("rx_bad_words", bad, 0);
      check("err_trailer", 32'(outs_w[g][O_ERR]), 32'(!tok));
      check("busy_idle", 32'(outs_w[g][O_BSY]), 0);
   endtask

   task automatic abort_frame(input int g);
      int s_done;
      prep(g, 1'b0, 1'b1);
      s_done = done_a[g];
      pulse_start(g);
      repeat (1001) @(negedge clk50);
      check("mid_busy", 32'(outs_w[g][O_BSY]), 1);
      check("mid_inc", 32'(outs_w[g][O_INC]), 1);
      rst = 1'b1;
      @(negedge clk50);
      check("rst_outs", 32'(outs_w[g]), 0);
      rst = 1'b0;
      repeat (40) @(negedge clk50);
      check("rst_no_done", done_a[g] - s_done, 0);
      check("rst_idle", 32'(outs_w[g]), 0);
   endtask

   initial begin
      for (int g = 0; g < 2; g++) begin
         hdr_v[g]  = '0;
         trl_v[g]  = '0;
         trl_ok[g] = 1'b0;
         for (int i = 0; i < NW; i++) data_v[g][i] = '0;
      end
      repeat (3) @(negedge clk50);
      check("reset_outs0", 32'(outs_w[0]), 0);
      check("reset_outs1", 32'(outs_w[1]), 0);
      rst = 1'b0;

      run_frame(0, 1'b1, 1'b1, 1'b0);
      run_frame(0, 1'b0, 1'b0, 1'b0);
      repeat (20) @(negedge clk50);
      check("err_sticky", 32'(outs_w[0][O_ERR]), 1);
      run_frame(0, 1'b0, 1'b1, 1'b1);
      repeat (10) @(negedge clk50);
      check("poke_ignored", 32'(outs_w[0][O_BSY]), 0);
      abort_frame(0);
      run_frame(0, 1'b0, 1'b1, 1'b0);
      run_frame(1, 1'b1, 1'b1, 1'b0);
      run_frame(1, 1'b0, 1'b0, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
